sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Sits between the memory stage and the external 16-bit SRAM.
- Converts one 32-bit load or store from the memory stage into two 16-bit SRAM accesses, low half first.
- Drives the SRAM control pins and generates the `ready` signal. The pipeline freezes every stage while `ready` is low.

Parameters:
- BASE_ADDR, 1024: byte address of data memory word 0. It is subtracted before mapping to the SRAM.
- WAIT_CYCLES, 3: extra idle cycles after the two SRAM accesses, modelling settle time. Legal range is 0..15.

Ports:
- clk input 1: system clock, rising edge.
- rst input 1: asynchronous, active-high reset.
- wr_en input 1: store request, held until the cycle in which `ready`=1.
- rd_en input 1: load request, held until the cycle in which `ready`=1.
- address input 32: byte address from the ALU result.
- write_data input 32: store data (Rm value).
- read_data output 32: load result, valid in the cycle `ready`=1 and held afterwards.
- ready output 1: high when no access is pending or the access is done.
- SRAM_DQ inout 16: SRAM data bus.
- SRAM_ADDR output 18: SRAM halfword address.
- SRAM_UB_N output 1: upper byte enable, tied 0.
- SRAM_LB_N output 1: lower byte enable, tied 0.
- SRAM_WE_N output 1: write enable, active low.
- SRAM_CE_N output 1: chip enable, tied 0.
- SRAM_OE_N output 1: output enable, tied 0.

Behaviour:
- States: IDLE, ACC_LO, ACC_HI, WAIT, DONE. State, counter and data registers update on the rising edge of clk; rst clears them asynchronously.
- Reset values:
  - State = IDLE, wait counter = 0, read_data = 0.
  - SRAM_WE_N = 1, SRAM_ADDR = 0, SRAM_DQ = high-Z.
  - ready = 1 when no request is present.
- Address map:
  - word = (address - BASE_ADDR) >> 2, using bits [16:0].
  - Low half: SRAM_ADDR = {word, 0}. High half: SRAM_ADDR = {word, 1}.
  - Bits [1:0] of `address` are ignored; accesses are word-aligned.
- Request capture: in IDLE, if rd_en or wr_en is 1, go to ACC_LO and latch `address`, `write_data`, and op. If both enables are 1, the write wins and is treated as a store only.
- ACC_LO:
  - Drive the low-half address.
  - Store: SRAM_WE_N = 0 and SRAM_DQ = write_data[15:0].
  - Load: SRAM_WE_N = 1, SRAM_DQ = Z, and read_data[15:0] captures SRAM_DQ at the clock edge.
  - Then go to ACC_HI.
- ACC_HI: same as ACC_LO with the high-half address and bits [31:16].
- WAIT:
  - SRAM_WE_N = 1 and SRAM_DQ = Z.
  - The counter counts 0..WAIT_CYCLES-1, then the state moves to DONE.
  - If WAIT_CYCLES = 0, ACC_HI goes directly to DONE.
- DONE: ready = 1 for exactly one cycle, then the state returns to IDLE unconditionally; the request still asserted in DONE is not re-captured.
- ready (combinational): ready = ~(rd_en | wr_en) | (state == DONE).
- Latency: with a request first seen in IDLE at cycle 0, ready is low for cycles 0..2+WAIT_CYCLES and high at cycle 3+WAIT_CYCLES (cycle 6 with the default).
- Back-to-back requests: the next request is captured in the IDLE cycle after DONE. There is no bubble beyond that cycle.
- SRAM_DQ is driven only in store ACC_LO and store ACC_HI; it is high-Z in all other states.
- Request dropped mid-access: the access still completes, because it uses the latched op and address.
- Reset mid-access: the FSM returns to IDLE immediately and SRAM_WE_N goes to 1. A partial store may remain in the SRAM; this is accepted.
- read_data is unchanged by stores and by reset-free idle cycles.

Test Plan:
- Reset asserted during ACC_HI of a store -> SRAM_WE_N = 1 and DQ = Z immediately; ready = 1 once rst falls with no request; read_data = 0.
- Store with wr_en = 1, address = 1028, write_data = 0xDEADBEEF -> SRAM halfwords at address 2 and 3 receive 0xBEEF then 0xDEAD; SRAM_WE_N is low for exactly 2 cycles; ready is low for cycles 0..5 and high at cycle 6.
- Load with rd_en = 1 at address 1028 after the store above -> read_data = 0xDEADBEEF when ready = 1; SRAM_WE_N stays 1 throughout.
- Back-to-back: store 0x12345678 at 1024 held through DONE, then load from 1024 the next cycle -> second access starts the cycle after DONE; read_data = 0x12345678; no double store.
- rd_en and wr_en both 1 at address 1032 with write_data = 0x0000CAFE -> treated as a store; SRAM address 4 = 0xCAFE, address 5 = 0x0000; read_data unchanged.
- WAIT_CYCLES = 0 instance, load from 1024 -> ready rises 3 cycles after the request; no request -> ready = 1 and SRAM_DQ = Z continuously.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges one 32-bit load/store from the memory stage onto a
// 16-bit asynchronous SRAM as two halfword accesses (low half first),
// followed by WAIT_CYCLES settle cycles. The pipeline is held off via ready.
`timescale 1ns/1ps

module sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        WAIT,
        DONE
    } state_t;

    // Last value of the settle counter before leaving WAIT.
    localparam logic [3:0] LAST_CNT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nxt;

    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        op_wr_q;

    logic [16:0] word_in;
    logic        dq_oe;
    logic [15:0] dq_out;

    // Word index relative to the data memory base; byte offset bits dropped.
    assign word_in = 17'((address - 32'(BASE_ADDR)) >> 2);

    // State and settle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic; DONE always falls back to IDLE so a request still held
    // in DONE is not captured twice.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_nxt = ACC_LO;
                end
            end
            ACC_LO: begin
                state_nxt = ACC_HI;
            end
            ACC_HI: begin
                wait_cnt_nxt = '0;
                state_nxt    = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == LAST_CNT) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Latch the request in IDLE; a write wins when both enables are set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
        end else if (state == IDLE && (rd_en || wr_en)) begin
            word_q  <= word_in;
            wdata_q <= write_data;
            op_wr_q <= wr_en;
        end
    end

    // SRAM address, write strobe and data bus drive for each state.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            ACC_LO: begin
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = wdata_q[15:0];
            end
            ACC_HI: begin
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = wdata_q[31:16];
            end
            default: begin
                SRAM_ADDR = '0;
            end
        endcase
    end

    // Load data capture, one halfword per access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (!op_wr_q) begin
            if (state == ACC_LO) begin
                read_data[15:0] <= SRAM_DQ;
            end else if (state == ACC_HI) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign ready     = ~(rd_en | wr_en) | (state == DONE);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: drives sram_ctrl against a bench-side SRAM model and checks
// loads, stores, latency and bus behaviour against a halfword-array reference.
`timescale 1ns/1ps

module tb_sram_ctrl;

    localparam int unsigned BASE = 1024;
    localparam int          W    = 3;
    localparam int          LAT  = 3 + W;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    logic        rd_en0;
    logic [31:0] address0;
    logic [31:0] read_data0;
    logic        ready0;
    wire  [15:0] sram_dq0;
    logic [17:0] sram_addr0;
    logic        ub0, lb0, we0, ce0, oe0;

    logic [15:0] sram_mem [0:255];
    logic [15:0] ref_mem  [0:255];
    wr_rec_t     wlog[$];
    logic [31:0] ref_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
        .SRAM_WE_N(sram_we_n), .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
    );

    sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd_en0),
        .address(address0), .write_data(32'h0),
        .read_data(read_data0), .ready(ready0), .SRAM_DQ(sram_dq0),
        .SRAM_ADDR(sram_addr0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0),
        .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] init_val0(input int i);
        return 16'((i * 2654435) ^ 16'hC3A5);
    endfunction

    // Halfword SRAM address from a byte address: word index, then half select.
    function automatic logic [7:0] hw_idx(input logic [31:0] a, input bit hi);
        int unsigned word;
        word = ((a - BASE) / 4) % 131072;
        return 8'((word * 2 + (hi ? 1 : 0)) % 256);
    endfunction

    // SRAM with OE tied low: drives the bus whenever it is not being written.
    assign sram_dq  = sram_we_n ? sram_mem[sram_addr[7:0]] : 16'hzzzz;
    assign sram_dq0 = we0 ? init_val0(int'(sram_addr0[7:0])) : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!sram_we_n) begin
                sram_mem[sram_addr[7:0]] = sram_dq;
                wlog.push_back('{a: sram_addr, d: sram_dq});
            end
        end
    end

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] d, input bit drop,
                             output int lat, output int we_cnt,
                             output logic [31:0] rd_snap);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        lat = -1; we_cnt = 0; rd_snap = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!sram_we_n) we_cnt++;
            if (drop ? (c == LAT) : (ready === 1'b1)) begin
                lat = c;
                rd_snap = read_data;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            if (drop && c == 0) begin
                wr_en = 1'b0; rd_en = 1'b0;
                address = $urandom; write_data = $urandom;
            end
        end
    endtask

    task automatic release_req();
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
        checks++; if (sram_dq !== ref_mem[0]) begin errors++; $display("FAIL reset_dq_released: got %h expected %h", sram_dq, ref_mem[0]); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] d;
        d = $urandom;
        wr_en = 1'b1; address = BASE + 40; write_data = d;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        ref_mem[hw_idx(BASE + 40, 0)] = d[15:0];
        #1;
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL midrst_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", sram_addr); end
        checks++; if (sram_dq !== ref_mem[0]) begin errors++; $display("FAIL midrst_dq_released: got %h expected %h", sram_dq, ref_mem[0]); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL midrst_read_data: got %h expected 0", read_data); end
        checks++; if (sram_mem[20] !== ref_mem[20]) begin errors++; $display("FAIL midrst_lo_half: got %h expected %h", sram_mem[20], ref_mem[20]); end
        checks++; if (sram_mem[21] !== ref_mem[21]) begin errors++; $display("FAIL midrst_hi_half: got %h expected %h", sram_mem[21], ref_mem[21]); end
        ref_rd = 32'd0;
    endtask

    task automatic test_store();
        int lat, wec, base;
        logic [31:0] snap;
        base = wlog.size();
        do_access(1, 0, 32'd1028, 32'hDEADBEEF, 0, lat, wec, snap);
        release_req();
        ref_mem[2] = 16'hBEEF; ref_mem[3] = 16'hDEAD;
        checks++; if (lat !== 6) begin errors++; $display("FAIL store_latency: got %0d expected 6", lat); end
        checks++; if (wec !== 2) begin errors++; $display("FAIL store_we_cycles: got %0d expected 2", wec); end
        checks++; if (wlog.size() - base !== 2) begin errors++; $display("FAIL store_write_count: got %0d expected 2", wlog.size() - base); end
        else begin
            checks++; if (wlog[base].a !== 18'd2 || wlog[base].d !== 16'hBEEF) begin errors++; $display("FAIL store_first_write: got %h/%h expected 2/beef", wlog[base].a, wlog[base].d); end
            checks++; if (wlog[base+1].a !== 18'd3 || wlog[base+1].d !== 16'hDEAD) begin errors++; $display("FAIL store_second_write: got %h/%h expected 3/dead", wlog[base+1].a, wlog[base+1].d); end
        end
        checks++; if (snap !== ref_rd) begin errors++; $display("FAIL store_read_data_kept: got %h expected %h", snap, ref_rd); end
    endtask

    task automatic test_load();
        int lat, wec;
        logic [31:0] snap;
        do_access(0, 1, 32'd1028, 32'h0, 0, lat, wec, snap);
        release_req();
        ref_rd = {ref_mem[3], ref_mem[2]};
        checks++; if (lat !== 6) begin errors++; $display("FAIL load_latency: got %0d expected 6", lat); end
        checks++; if (wec !== 0) begin errors++; $display("FAIL load_we_cycles: got %0d expected 0", wec); end
        checks++; if (snap !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", snap); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data_held: got %h expected deadbeef", read_data); end
    endtask

    task automatic test_both_enables();
        int lat, wec, base;
        logic [31:0] snap;
        base = wlog.size();
        do_access(1, 1, 32'd1032, 32'h0000CAFE, 0, lat, wec, snap);
        release_req();
        ref_mem[4] = 16'hCAFE; ref_mem[5] = 16'h0000;
        checks++; if (wec !== 2) begin errors++; $display("FAIL both_we_cycles: got %0d expected 2", wec); end
        checks++; if (sram_mem[4] !== 16'hCAFE) begin errors++; $display("FAIL both_lo_half: got %h expected cafe", sram_mem[4]); end
        checks++; if (sram_mem[5] !== 16'h0000) begin errors++; $display("FAIL both_hi_half: got %h expected 0000", sram_mem[5]); end
        checks++; if (wlog.size() - base !== 2) begin errors++; $display("FAIL both_write_count: got %0d expected 2", wlog.size() - base); end
        checks++; if (snap !== ref_rd) begin errors++; $display("FAIL both_read_data_kept: got %h expected %h", snap, ref_rd); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, wec1, wec2, base;
        logic [31:0] snap;
        base = wlog.size();
        do_access(1, 0, 32'd1024, 32'h12345678, 0, lat1, wec1, snap);
        do_access(0, 1, 32'd1024, 32'h0, 0, lat2, wec2, snap);
        release_req();
        ref_mem[0] = 16'h5678; ref_mem[1] = 16'h1234;
        ref_rd = {ref_mem[1], ref_mem[0]};
        checks++; if (lat1 !== LAT) begin errors++; $display("FAIL b2b_store_latency: got %0d expected %0d", lat1, LAT); end
        checks++; if (lat2 !== LAT) begin errors++; $display("FAIL b2b_load_latency: got %0d expected %0d", lat2, LAT); end
        checks++; if (wlog.size() - base !== 2) begin errors++; $display("FAIL b2b_single_store: got %0d writes expected 2", wlog.size() - base); end
        checks++; if (wec2 !== 0) begin errors++; $display("FAIL b2b_load_we_cycles: got %0d expected 0", wec2); end
        checks++; if (snap !== 32'h12345678) begin errors++; $display("FAIL b2b_load_data: got %h expected 12345678", snap); end
    endtask

    task automatic test_random();
        int lat, wec, base, op;
        bit wr, rd, drop;
        logic [31:0] a, d, snap;
        logic [7:0] lo, hi;
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 2);
            wr   = (op != 0);
            rd   = (op != 1);
            a    = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
            d    = $urandom;
            drop = ($urandom_range(0, 3) == 0);
            lo   = hw_idx(a, 0);
            hi   = hw_idx(a, 1);
            base = wlog.size();
            do_access(wr, rd, a, d, drop, lat, wec, snap);
            if (wr) begin
                ref_mem[lo] = d[15:0];
                ref_mem[hi] = d[31:16];
                checks++; if (wec !== 2) begin errors++; $display("FAIL rnd_store_we_cycles[%0d]: got %0d expected 2", n, wec); end
                checks++; if (wlog.size() - base !== 2) begin errors++; $display("FAIL rnd_store_writes[%0d]: got %0d expected 2", n, wlog.size() - base); end
                checks++; if (sram_mem[lo] !== ref_mem[lo] || sram_mem[hi] !== ref_mem[hi]) begin
                    errors++; $display("FAIL rnd_store_mem[%0d]: got %h%h expected %h%h", n, sram_mem[hi], sram_mem[lo], ref_mem[hi], ref_mem[lo]);
                end
            end else begin
                ref_rd = {ref_mem[hi], ref_mem[lo]};
                checks++; if (wec !== 0) begin errors++; $display("FAIL rnd_load_we_cycles[%0d]: got %0d expected 0", n, wec); end
            end
            checks++; if (snap !== ref_rd) begin errors++; $display("FAIL rnd_read_data[%0d]: got %h expected %h", n, snap, ref_rd); end
            if (!drop) begin
                checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, LAT); end
            end
            if ($urandom_range(0, 1) == 1) begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
        end
        release_req();
    endtask

    task automatic test_wait0();
        int lat;
        logic [31:0] snap, expv;
        expv = {init_val0(1), init_val0(0)};
        lat = -1; snap = '0;
        rd_en0 = 1'b1; address0 = 32'd1024;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready0 === 1'b1) begin
                lat = c; snap = read_data0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd_en0 = 1'b0;
        checks++; if (lat !== 3) begin errors++; $display("FAIL w0_latency: got %0d expected 3", lat); end
        checks++; if (snap !== expv) begin errors++; $display("FAIL w0_load_data: got %h expected %h", snap, expv); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL w0_idle_ready[%0d]: got %b expected 1", c, ready0); end
            checks++; if (we0 !== 1'b1 || sram_addr0 !== 18'd0) begin errors++; $display("FAIL w0_idle_bus[%0d]: got we %b addr %h expected 1/0", c, we0, sram_addr0); end
            checks++; if (sram_dq0 !== init_val0(0)) begin errors++; $display("FAIL w0_idle_dq[%0d]: got %h expected %h", c, sram_dq0, init_val0(0)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        rd_en0 = 1'b0; address0 = '0;
        ref_rd = '0;
        test_reset();
        test_reset_mid_store();
        test_store();
        test_load();
        test_both_enables();
        test_back_to_back();
        test_random();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
